// File: rtl/dec_pkg.sv
// dec_pkg: shared encodings for the decode stage.
//   EXT_* : immediate extension selects (in_ext_op)
//   CMP_* : branch compare selects (in_cmp_op); unlisted codes never take
//   TW_DEFAULT : default width of Tuse/Tnew fields
package dec_pkg;

  localparam int TW_DEFAULT = 3;

  localparam logic [1:0] EXT_ZERO = 2'b00;  // zero-extend imm
  localparam logic [1:0] EXT_SIGN = 2'b01;  // sign-extend imm
  localparam logic [1:0] EXT_HIGH = 2'b10;  // imm << 16, zero-filled
  localparam logic [1:0] EXT_NONE = 2'b11;  // all zeros

  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_GEZ = 3'b001;
  localparam logic [2:0] CMP_GTZ = 3'b010;
  localparam logic [2:0] CMP_LEZ = 3'b011;
  localparam logic [2:0] CMP_LTZ = 3'b100;
  localparam logic [2:0] CMP_NE  = 3'b101;

endpackage

// File: rtl/dec_regfile.sv
// dec_regfile: NREG x XLEN register file, two read ports, one write port.
//   clk, rst_n          : clock, asynchronous active-low clear of every entry
//   we, waddr, wdata    : write port; writes to register 0 are dropped
//   raddr1/2, rdata1/2  : combinational reads; register 0 reads 0, and a
//                         same-cycle write to the read address is bypassed
module dec_regfile
  import dec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic            wr_ok;

  // Addresses beyond NREG-1 only occur when NREG is not a power of two.
  assign wr_ok = we && (waddr != '0) && (int'(waddr) < NREG);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    if (a == '0 || int'(a) >= NREG) v = '0;
    else if (wr_ok && waddr == a)  v = wdata;   // write-first
    else                           v = mem_q[a];
    return v;
  endfunction

  assign rdata1 = read_port(raddr1);
  assign rdata2 = read_port(raddr2);

endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: decode stage between the F/D register and the E stage.
// Reads operands (register file + multi-source forwarding), detects Tuse/Tnew
// stalls, evaluates the branch compare, extends the immediate and holds the
// D->E payload in an output register.
//   clk, reset            : clock; asynchronous active-low reset
//   in_*                  : pre-decoded instruction with in_valid/in_ready
//   fwd_*                 : NFWD producer slots, index 0 youngest
//   wb_*                  : register-file write port
//   flush                 : drop the output payload and the current input
//   br_taken              : combinational branch decision for an accepted instr
//   out_*                 : registered payload with out_valid/out_ready
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. out_valid never drops without a transfer unless flush or reset. in_ready
// is 1 during flush because the input is being discarded, not consumed.
module decode_stage_p
  import dec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NFWD = 2,
  parameter int TW   = TW_DEFAULT,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [AW-1:0]        in_rs,
  input  logic [AW-1:0]        in_rt,
  input  logic [TW-1:0]        in_tuse_rs,
  input  logic [TW-1:0]        in_tuse_rt,
  input  logic [TW-1:0]        in_tnew,
  input  logic [AW-1:0]        in_wr,
  input  logic [15:0]          in_imm,
  input  logic [1:0]           in_ext_op,
  input  logic [2:0]           in_cmp_op,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*TW-1:0]   fwd_tnew,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic                 br_taken,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_rd1,
  output logic [XLEN-1:0]      out_rd2,
  output logic [XLEN-1:0]      out_ext,
  output logic [AW-1:0]        out_wr,
  output logic [TW-1:0]        out_tnew
);

  logic [XLEN-1:0] rf_rd1, rf_rd2;

  dec_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk    (clk),
    .rst_n  (reset),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (in_rs),
    .raddr2 (in_rt),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // Lowest-index matching producer per source. The loop runs from the oldest
  // slot down so the youngest match is the one left standing.
  logic            rs_hit, rt_hit;
  logic [TW-1:0]   rs_ptnew, rt_ptnew;
  logic [XLEN-1:0] rs_pdata, rt_pdata;

  always_comb begin
    rs_hit   = 1'b0;
    rs_ptnew = '0;
    rs_pdata = '0;
    rt_hit   = 1'b0;
    rt_ptnew = '0;
    rt_pdata = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && in_rs != '0 && fwd_addr[i*AW +: AW] == in_rs) begin
        rs_hit   = 1'b1;
        rs_ptnew = fwd_tnew[i*TW +: TW];
        rs_pdata = fwd_data[i*XLEN +: XLEN];
      end
      if (fwd_valid[i] && in_rt != '0 && fwd_addr[i*AW +: AW] == in_rt) begin
        rt_hit   = 1'b1;
        rt_ptnew = fwd_tnew[i*TW +: TW];
        rt_pdata = fwd_data[i*XLEN +: XLEN];
      end
    end
  end

  // A producer still in flight (tnew != 0) yields the register value; if it
  // is not needed yet, a later stage forwards the real result.
  logic [XLEN-1:0] rd1, rd2;
  logic            hazard;

  assign rd1    = (rs_hit && rs_ptnew == '0) ? rs_pdata : rf_rd1;
  assign rd2    = (rt_hit && rt_ptnew == '0) ? rt_pdata : rf_rd2;
  assign hazard = (rs_hit && rs_ptnew > in_tuse_rs) ||
                  (rt_hit && rt_ptnew > in_tuse_rt);

  logic [XLEN-1:0] ext_val;

  always_comb begin
    ext_val = '0;
    unique case (in_ext_op)
      EXT_ZERO: ext_val[15:0] = in_imm;
      EXT_SIGN: ext_val = {{(XLEN-16){in_imm[15]}}, in_imm};
      EXT_HIGH: ext_val[31:0] = {in_imm, 16'h0000};
      default:  ext_val = '0;
    endcase
  end

  logic cmp_true;
  logic rd1_neg, rd1_zero;

  assign rd1_neg  = rd1[XLEN-1];
  assign rd1_zero = (rd1 == '0);

  always_comb begin
    cmp_true = 1'b0;
    case (in_cmp_op)
      CMP_EQ:  cmp_true = (rd1 == rd2);
      CMP_GEZ: cmp_true = !rd1_neg;
      CMP_GTZ: cmp_true = !rd1_neg && !rd1_zero;
      CMP_LEZ: cmp_true = rd1_neg || rd1_zero;
      CMP_LTZ: cmp_true = rd1_neg;
      CMP_NE:  cmp_true = (rd1 != rd2);
      default: cmp_true = 1'b0;
    endcase
  end

  logic out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d, out_rd1_q, out_rd1_d;
  logic [XLEN-1:0] out_rd2_q, out_rd2_d, out_ext_q, out_ext_d;
  logic [AW-1:0]   out_wr_q, out_wr_d;
  logic [TW-1:0]   out_tnew_q, out_tnew_d;
  logic            space, accept;

  assign space    = !out_valid_q || out_ready;
  assign in_ready = reset && (flush || (space && !hazard));
  assign accept   = in_valid && in_ready && !flush;
  assign br_taken = accept && cmp_true;

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_rd1_d   = out_rd1_q;
    out_rd2_d   = out_rd2_q;
    out_ext_d   = out_ext_q;
    out_wr_d    = out_wr_q;
    out_tnew_d  = out_tnew_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_pc_d    = in_pc;
      out_rd1_d   = rd1;
      out_rd2_d   = rd2;
      out_ext_d   = ext_val;
      out_wr_d    = in_wr;
      out_tnew_d  = (in_tnew == '0) ? '0 : in_tnew - TW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_rd1_q   <= '0;
      out_rd2_q   <= '0;
      out_ext_q   <= '0;
      out_wr_q    <= '0;
      out_tnew_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_rd1_q   <= out_rd1_d;
      out_rd2_q   <= out_rd2_d;
      out_ext_q   <= out_ext_d;
      out_wr_q    <= out_wr_d;
      out_tnew_q  <= out_tnew_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_rd1   = out_rd1_q;
  assign out_rd2   = out_rd2_q;
  assign out_ext   = out_ext_q;
  assign out_wr    = out_wr_q;
  assign out_tnew  = out_tnew_q;

endmodule
